// File: rtl/mem_pkg.sv
// Memory access modes, store-buffer entry layout and size/extension helpers.
// Shared by store_buffer and its per-entry overlap checker.
package mem_pkg;

    localparam int ADDR_W = 32;

    typedef enum logic [2:0] {
        BYTE      = 3'b000,
        HALFWORD  = 3'b001,
        WORD      = 3'b010,
        UBYTE     = 3'b011,
        UHALFWORD = 3'b100
    } mem_mode_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        mem_mode_e         mode;
    } stb_entry_t;

    // Unknown encodings are treated as full words so they never under-report an overlap.
    function automatic logic [2:0] mode_size(input mem_mode_e m);
        case (m)
            BYTE, UBYTE:         return 3'd1;
            HALFWORD, UHALFWORD: return 3'd2;
            default:             return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] ld_extend(input logic [31:0] d, input mem_mode_e m);
        case (m)
            BYTE:      return {{24{d[7]}}, d[7:0]};
            HALFWORD:  return {{16{d[15]}}, d[15:0]};
            UBYTE:     return {24'h0, d[7:0]};
            UHALFWORD: return {16'h0, d[15:0]};
            default:   return d;
        endcase
    endfunction

endpackage

// File: rtl/stb_overlap_chk.sv
// Purpose: compares one store-buffer entry's byte range against the load byte range.
// Latency: combinational. Backpressure: none.
module stb_overlap_chk
    import mem_pkg::*;
#(
    parameter int AW = ADDR_W
) (
    input  logic          entry_vld,
    input  logic [AW-1:0] entry_addr,
    input  mem_mode_e     entry_mode,
    input  logic [AW-1:0] ld_addr,
    input  mem_mode_e     ld_mode,
    output logic          hit,
    output logic          exact_match
);

    // One extra bit on the range ends so ranges near the top of memory do not wrap.
    logic [AW:0] st_end;
    logic [AW:0] ld_end;

    assign st_end = {1'b0, entry_addr} + (AW+1)'(mode_size(entry_mode));
    assign ld_end = {1'b0, ld_addr} + (AW+1)'(mode_size(ld_mode));

    assign hit         = entry_vld && ({1'b0, entry_addr} < ld_end) && ({1'b0, ld_addr} < st_end);
    assign exact_match = entry_vld && (entry_addr == ld_addr);

endmodule

// File: rtl/store_buffer.sv
// Purpose: FIFO of committed stores draining one per cycle into data_mem; guards loads against pending stores.
// Latency: pushed store drainable next cycle; load result/stall combinational. Optional macro: STB_FWD_EN.
// Backpressure: st_ready low when full or flushing; loads own the memory port, conflicting loads stall.
module store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = ADDR_W   // must equal ADDR_W, the entry address width
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_data,
    input  logic [2:0]    st_mode,
    input  logic          drain_en,
    input  logic          flush,
    output logic          flush_done,
    output logic          empty,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [2:0]    mem_mode,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [2:0]    ld_mode,
    input  logic [31:0]   mem_rdata,
    output logic [31:0]   ld_data,
    output logic          ld_stall
);

    localparam int PW = $clog2(DEPTH);

    stb_entry_t       ent_q [DEPTH];
    stb_entry_t       head_ent;
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [PW:0]      count_q;
    logic             push;
    logic             drain;
    logic [PW-1:0]    age [DEPTH];
    logic [DEPTH-1:0] ent_vld;
    logic [DEPTH-1:0] hit;
    logic [DEPTH-1:0] exact;

    assign empty      = (count_q == '0);
    assign st_ready   = (count_q != (PW+1)'(DEPTH)) && !flush;
    assign flush_done = flush && empty;
    assign push       = st_valid && st_ready;
    // A load owns the shared address port, so draining waits for a load-free cycle.
    assign drain      = !empty && drain_en && !ld_valid;

    assign head_ent  = ent_q[head_q];
    assign mem_wr_en = drain;
    assign mem_addr  = ld_valid ? ld_addr : head_ent.addr;
    assign mem_wdata = head_ent.data;
    assign mem_mode  = ld_valid ? ld_mode : head_ent.mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push)
                tail_q <= tail_q + 1'b1;
            if (drain)
                head_q <= head_q + 1'b1;
            count_q <= count_q + (PW+1)'(push) - (PW+1)'(drain);
        end
    end

    // Payload needs no reset: count_q alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push)
            ent_q[tail_q] <= '{addr: st_addr, data: st_data, mode: mem_mode_e'(st_mode)};
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_chk
        assign age[i]     = PW'(i) - head_q;
        assign ent_vld[i] = ({1'b0, age[i]} < count_q);

        stb_overlap_chk #(.AW(AW)) u_chk (
            .entry_vld   (ent_vld[i]),
            .entry_addr  (ent_q[i].addr),
            .entry_mode  (ent_q[i].mode),
            .ld_addr     (ld_addr),
            .ld_mode     (mem_mode_e'(ld_mode)),
            .hit         (hit[i]),
            .exact_match (exact[i])
        );
    end

`ifdef STB_FWD_EN
    logic          sel_hit;
    logic [PW-1:0] sel_idx;
    logic [PW-1:0] sel_age;
    stb_entry_t    sel_ent;
    logic          fwd_ok;

    // Youngest overlapping entry is the one furthest from head.
    always_comb begin
        sel_hit = 1'b0;
        sel_idx = '0;
        sel_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (hit[i] && (!sel_hit || age[i] > sel_age)) begin
                sel_hit = 1'b1;
                sel_idx = PW'(i);
                sel_age = age[i];
            end
        end
    end

    assign sel_ent  = ent_q[sel_idx];
    assign fwd_ok   = exact[sel_idx] && (mode_size(sel_ent.mode) >= mode_size(mem_mode_e'(ld_mode)));
    assign ld_stall = ld_valid && sel_hit && !fwd_ok;
    assign ld_data  = (ld_valid && sel_hit && fwd_ok) ? ld_extend(sel_ent.data, mem_mode_e'(ld_mode))
                                                      : mem_rdata;
`else
    // An exact address match is always also an overlap; folding it in keeps both checker outputs live.
    assign ld_stall = ld_valid && |(hit | exact);
    assign ld_data  = mem_rdata;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a byte-addressed data_mem model and a write scoreboard.
module tb_store_buffer;
    import mem_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          st_valid, st_ready;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_data;
    logic [2:0]    st_mode;
    logic          drain_en, flush, flush_done, empty, mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [2:0]    mem_mode;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [2:0]    ld_mode;
    logic [31:0]   mem_rdata, ld_data;
    logic          ld_stall;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  mode;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         n_writes = 0;
    int         n_pushed = 0;
    int         writes_before_rst = 0;
    logic [7:0] dmem [256] = '{default: 8'h00};
    logic [7:0] ra;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data), .st_mode(st_mode),
        .drain_en(drain_en), .flush(flush), .flush_done(flush_done), .empty(empty),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mode(mem_mode),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_mode(ld_mode), .mem_rdata(mem_rdata),
        .ld_data(ld_data), .ld_stall(ld_stall)
    );

    // data_mem model: asynchronous little-endian read, byte-enabled write on posedge.
    assign ra        = mem_addr[7:0];
    assign mem_rdata = {dmem[ra + 8'd3], dmem[ra + 8'd2], dmem[ra + 8'd1], dmem[ra]};

    always @(posedge clk) begin
        if (rst_n && mem_wr_en) begin
            for (int b = 0; b < 4; b++)
                if (b < int'(mode_size(mem_mode_e'(mem_mode))))
                    dmem[ra + 8'(b)] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // Scoreboard: every issued write must match the oldest outstanding accepted store.
    always @(negedge clk) begin
        if (rst_n && mem_wr_en) begin
            exp_t e;
            n_writes++;
            n_checks++;
            assert (sb.size() != 0) n_pass++;
            else $error("FAIL wr_unexpected: observed write @%h, expected no write", mem_addr);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_addr", mem_addr, e.addr);
                chk("wr_data", mem_wdata, e.data);
                chk("wr_mode", {29'b0, mem_mode}, {29'b0, e.mode});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_mode  = m;
        #1;
        if (st_ready) begin
            sb.push_back('{addr: a, data: d, mode: m});
            n_pushed++;
        end
        step();
        st_valid = 1'b0;
    endtask

    task automatic load(input string tag, input logic [31:0] a, input logic [2:0] m,
                        input logic exp_stall, input logic [31:0] exp_data);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_mode  = m;
        #1;
        chk1({tag, "_stall"}, ld_stall, exp_stall);
        chk({tag, "_data"}, ld_data, exp_data);
    endtask

    task automatic wait_empty(input string tag);
        for (int c = 0; c < 30 && !empty; c++)
            step();
        chk1({tag, "_empty"}, empty, 1'b1);
        chk({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] fwd_b, fwd_ub, fwd_h, fwd_w, fwd_young;
        logic        fwd_stall;

        st_valid = 1'b0; st_addr = '0; st_data = '0; st_mode = WORD;
        drain_en = 1'b0; flush = 1'b0;
        ld_valid = 1'b0; ld_addr = '0; ld_mode = WORD;

        #12;
        chk1("rst_empty", empty, 1'b1);
        chk1("rst_st_ready", st_ready, 1'b1);
        chk1("rst_wr_en", mem_wr_en, 1'b0);
        chk1("rst_ld_stall", ld_stall, 1'b0);
        chk1("rst_flush_done", flush_done, 1'b0);
        chk("rst_ld_data", ld_data, mem_rdata);
        rst_n = 1'b1;
        step();

        // Idle with drain enabled: nothing to write.
        drain_en = 1'b1;
        repeat (3) step();
        chk1("idle_wr_en", mem_wr_en, 1'b0);

        // A store is drainable only from the cycle after it is pushed.
        st_valid = 1'b1; st_addr = 32'h40; st_data = 32'hA5A5_0001; st_mode = WORD;
        #1;
        chk1("lat_same_cycle_wr", mem_wr_en, 1'b0);
        chk1("lat_ready", st_ready, 1'b1);
        sb.push_back('{addr: 32'h40, data: 32'hA5A5_0001, mode: WORD});
        n_pushed++;
        step();
        st_valid = 1'b0;
        chk1("lat_next_cycle_wr", mem_wr_en, 1'b1);
        step();
        chk1("lat_empty", empty, 1'b1);

        // Fill to full with drain held off, then drain in order.
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(32'h10 + 32'(4*i), 32'h1000_0000 + 32'(i), WORD);
            chk1("fill_st_ready", st_ready, i < 3);
        end
        chk1("fill_not_empty", empty, 1'b0);
        drain_en = 1'b1;
        wait_empty("fill_drain");

        // Overlapping load stalls until the entry is written.
        drain_en = 1'b0;
        push(32'h20, 32'hDEAD_BEEF, WORD);
        drain_en = 1'b1;
        load("ld_ov22", 32'h22, WORD, 1'b1, 32'h0000_0000);
        chk1("ld_ov_wr_blocked", mem_wr_en, 1'b0);
        chk("ld_ov_addr_mux", mem_addr, 32'h22);
        step();
        chk1("ld_ov_still_stall", ld_stall, 1'b1);
        load("ld_ov1f_word", 32'h1F, WORD, 1'b1, 32'h0000_0010);
        load("ld_no1c_word", 32'h1C, WORD, 1'b0, 32'h1000_0003);
        load("ld_no1f_byte", 32'h1F, BYTE, 1'b0, 32'h0000_0010);
        load("ld_ov23_byte", 32'h23, BYTE, 1'b1, 32'h0000_0000);
        ld_valid = 1'b0;
        #1;
        chk1("ld_gap_wr", mem_wr_en, 1'b1);
        step();
        chk1("ld_gap_empty", empty, 1'b1);
        load("ld_after20", 32'h20, WORD, 1'b0, 32'hDEAD_BEEF);
        load("ld_after22", 32'h22, WORD, 1'b0, 32'h0000_DEAD);
        ld_valid = 1'b0;

        // Same-address loads: forwarded when enabled, otherwise stalled.
`ifdef STB_FWD_EN
        fwd_stall = 1'b0;
        fwd_b = 32'hFFFF_FFFF; fwd_ub = 32'h0000_00FF; fwd_h = 32'hFFFF_80FF; fwd_w = 32'h0000_80FF;
        fwd_young = 32'h0000_0078;
`else
        fwd_stall = 1'b1;
        fwd_b = 32'h0; fwd_ub = 32'h0; fwd_h = 32'h0; fwd_w = 32'h0;
        fwd_young = 32'h0;
`endif
        drain_en = 1'b0;
        push(32'h30, 32'h0000_80FF, WORD);
        load("fwd_byte", 32'h30, BYTE, fwd_stall, fwd_b);
        load("fwd_ubyte", 32'h30, UBYTE, fwd_stall, fwd_ub);
        load("fwd_half", 32'h30, HALFWORD, fwd_stall, fwd_h);
        load("fwd_word", 32'h30, WORD, fwd_stall, fwd_w);
        load("fwd_misaligned", 32'h31, BYTE, 1'b1, 32'h0);
        ld_valid = 1'b0;
        push(32'h30, 32'h1234_5678, WORD);
        load("fwd_youngest", 32'h30, BYTE, fwd_stall, fwd_young);
        ld_valid = 1'b0;
        drain_en = 1'b1;
        wait_empty("fwd_drain");

        // Flush blocks new stores and reports completion once empty.
        drain_en = 1'b0;
        push(32'h50, 32'hCAFE_0050, WORD);
        flush = 1'b1;
        #1;
        chk1("flush_st_ready", st_ready, 1'b0);
        chk1("flush_done_pending", flush_done, 1'b0);
        drain_en = 1'b1;
        step();
        chk1("flush_done_empty", flush_done, 1'b1);
        flush = 1'b0;
        #1;
        chk1("flush_done_release", flush_done, 1'b0);

        // Full buffer with continuous push attempts and draining: no loss, no duplication.
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++)
            push(32'h60 + 32'(4*i), 32'h6000_0000 + 32'(i), WORD);
        chk1("full_st_ready", st_ready, 1'b0);
        drain_en = 1'b1;
        for (int c = 0, k = 4; c < 20; c++) begin
            st_valid = 1'b1;
            st_addr  = 32'h60 + 32'(4*k);
            st_data  = 32'h6000_0000 + 32'(k);
            st_mode  = WORD;
            #1;
            chk1("steady_st_ready", st_ready, c != 0);
            chk1("steady_not_empty", empty, 1'b0);
            if (st_ready) begin
                sb.push_back('{addr: st_addr, data: st_data, mode: WORD});
                n_pushed++;
                k++;
            end
            step();
        end
        st_valid = 1'b0;
        wait_empty("steady_drain");
        chk("write_count", 32'(n_writes), 32'(n_pushed));

        // Reset with pending stores discards them without a write.
        drain_en = 1'b0;
        for (int i = 0; i < 3; i++)
            push(32'h80 + 32'(4*i), 32'h8000_0000 + 32'(i), WORD);
        writes_before_rst = n_writes;
        drain_en = 1'b1;
        #1;
        chk1("prerst_wr_en", mem_wr_en, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("rst_mid_wr_en", mem_wr_en, 1'b0);
        chk1("rst_mid_empty", empty, 1'b1);
        sb.delete();
        step();
        step();
        rst_n = 1'b1;
        repeat (5) step();
        chk1("postrst_empty", empty, 1'b1);
        chk("postrst_no_writes", 32'(n_writes), 32'(writes_before_rst));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
